regfile_wb_arbiter: RTL
=======================

// Module: regfile_wb_arbiter
// PURPOSE
// Shares the register file's single write port between two writeback requesters:
// s0 is the ALU/execute result, s1 is the memory load result.
// Round-robin arbitration with a valid/ready handshake; the winner is registered onto the write port.
// A per-register pending-write scoreboard lets issue logic stall on RAW hazards.
// Sits between the execute/memory stages and the 4-entry register file.
// PARAMETERS
// WORD_SIZE   16  data width of a register / write data
// NUM_REGS    4   number of architectural registers
// REG_AW      2   register address width, clog2(NUM_REGS)
// PORTS
// clk          in   1          clock, all state on posedge
// reset_n      in   1          synchronous active-low reset
// s0_valid     in   1          ALU writeback request
// s0_reg       in   REG_AW     ALU destination register
// s0_data      in   WORD_SIZE  ALU result
// s0_ready     out  1          ALU request granted this cycle (combinational)
// s1_valid     in   1          load writeback request
// s1_reg       in   REG_AW     load destination register
// s1_data      in   WORD_SIZE  load data
// s1_ready     out  1          load request granted this cycle (combinational)
// issue_valid  in   1          an instruction writing issue_reg has issued
// issue_reg    in   REG_AW     destination of the issued instruction
// rf_we        out  1          register-file write enable (registered)
// rf_wreg      out  REG_AW     register-file write address (registered)
// rf_wdata     out  WORD_SIZE  register-file write data (registered)
// busy         out  NUM_REGS   bit r=1: register r has >=1 outstanding write
// sb_overflow  out  1          sticky: issue to a register whose count is already 3
// BEHAVIOUR
// - Reset (reset_n=0 at posedge): rf_we=0, rf_wreg=0, rf_wdata=0.
//   All pending counts=0 (busy=0); sb_overflow=0; priority state=PRI0.
//   s0_ready=s1_ready=0 while reset_n=0; in-flight requests are discarded.
// - Priority FSM, 2 states: PRI0 (s0 wins ties), PRI1 (s1 wins ties).
//   Contended grant (both valid): move to the other state.
//   Uncontended grant or idle: state unchanged.
// - Grant: exactly one of s0_ready/s1_ready is high when any valid is high.
//   Neither is high when no valid is high.
//   A lone valid requester is granted regardless of state.
// - Handshake: a transfer occurs when valid&&ready.
//   The loser keeps valid high, holds reg and data stable until granted, and must not drop the request.
// - Latency: a transfer at edge N drives rf_we=1, rf_wreg, rf_wdata for cycle N..N+1.
//   The register file commits the write at edge N+1.
//   No transfer at N: rf_we=0 next cycle; rf_wreg and rf_wdata hold their values.
// - Throughput: one write per cycle; no internal buffering beyond the output register.
// - Scoreboard: each register r has a 2-bit count cnt[r]; busy[r]=(cnt[r]!=0), registered.
//   issue_valid increments cnt[issue_reg].
//   A transfer decrements cnt of the granted reg (at acceptance, not at rf_we).
// - Same-cycle issue and retire on the same reg: net 0, count unchanged.
// - Issue when cnt=3: count saturates at 3 and sb_overflow is set (sticky until reset).
//   Exception: a same-cycle retire to that reg makes the net 0 and is not an overflow.
// - Retire when cnt=0 (untracked write): count stays 0; this is not an error.
// - s0_reg==s1_reg with both valid: serialised by arbitration; the second write lands one cycle later.
// TESTING
// 1 Reset: hold reset_n=0 with s0_valid=1 -> s0_ready=0, rf_we=0, busy=4'b0000.
//   Release -> s0 granted on the first cycle.
// 2 Lone request: s0 reg=2 data=16'h1234 at edge N.
//   -> rf_we=1, rf_wreg=2, rf_wdata=16'h1234 after edge N; rf_we=0 the cycle after.
// 3 Contention: s0 and s1 valid for 4 cycles, regs 1 and 3 (resubmitted after grant).
//   -> grants s0,s1,s0,s1; rf_wreg 1,3,1,3 on consecutive cycles.
// 4 Scoreboard: issue reg1 twice -> busy=4'b0010.
//   One s1 retire to reg1 -> still 4'b0010; second retire -> 4'b0000.
// 5 Simultaneous: cnt[2]=1; same cycle issue reg2 + s0 retire reg2 -> busy[2]=1, count stays 1.
//   Also issue reg0 four times -> sb_overflow=1, busy[0]=1.
// 6 Mid-operation reset: s1 waiting, busy=4'b1010, priority state=PRI1.
//   Pulse reset_n=0 one cycle -> all cleared; s0 wins the next tie (PRI0).

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the register-file write port between the ALU (s0)
// and load (s1) writeback paths, with a per-register pending-write scoreboard.
module regfile_wb_arbiter #(
  parameter int WORD_SIZE = 16,
  parameter int NUM_REGS  = 4,
  parameter int REG_AW    = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 s0_valid,
  input  logic [REG_AW-1:0]    s0_reg,
  input  logic [WORD_SIZE-1:0] s0_data,
  output logic                 s0_ready,
  input  logic                 s1_valid,
  input  logic [REG_AW-1:0]    s1_reg,
  input  logic [WORD_SIZE-1:0] s1_data,
  output logic                 s1_ready,
  input  logic                 issue_valid,
  input  logic [REG_AW-1:0]    issue_reg,
  output logic                 rf_we,
  output logic [REG_AW-1:0]    rf_wreg,
  output logic [WORD_SIZE-1:0] rf_wdata,
  output logic [NUM_REGS-1:0]  busy,
  output logic                 sb_overflow
);

  typedef enum logic [0:0] {PRI0 = 1'b0, PRI1 = 1'b1} pri_t;

  pri_t                       pri_r, pri_nxt_s;
  logic                       grant0_s, grant1_s, xfer_s;
  logic [REG_AW-1:0]          win_reg_s;
  logic [WORD_SIZE-1:0]       win_data_s;
  logic [NUM_REGS-1:0]        inc_s, dec_s, busy_nxt_s, busy_r;
  logic [NUM_REGS-1:0][1:0]   cnt_r, cnt_nxt_s;
  logic                       ovf_nxt_s, ovf_r;
  logic                       rf_we_r;
  logic [REG_AW-1:0]          rf_wreg_r;
  logic [WORD_SIZE-1:0]       rf_wdata_r;

  // Grant selection and priority next-state; ties alternate, lone requests win outright.
  always_comb begin
    grant0_s  = 1'b0;
    grant1_s  = 1'b0;
    pri_nxt_s = pri_r;
    if (!reset_n) begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
    end else if (s0_valid && s1_valid) begin
      case (pri_r)
        PRI0: begin
          grant0_s  = 1'b1;
          pri_nxt_s = PRI1;
        end
        PRI1: begin
          grant1_s  = 1'b1;
          pri_nxt_s = PRI0;
        end
        default: begin
          grant0_s  = 1'b1;
          pri_nxt_s = PRI1;
        end
      endcase
    end else begin
      grant0_s = s0_valid;
      grant1_s = s1_valid;
    end
  end

  assign s0_ready   = grant0_s;
  assign s1_ready   = grant1_s;
  assign xfer_s     = grant0_s | grant1_s;
  assign win_reg_s  = grant0_s ? s0_reg  : s1_reg;
  assign win_data_s = grant0_s ? s0_data : s1_data;

  // Per-register issue/retire strobes.
  always_comb begin
    inc_s = {NUM_REGS{1'b0}};
    dec_s = {NUM_REGS{1'b0}};
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_s[r] = issue_valid && (issue_reg == REG_AW'(r));
      dec_s[r] = xfer_s && (win_reg_s == REG_AW'(r));
    end
  end

  // Saturating pending counts; a retire to an untracked register is silently ignored.
  always_comb begin
    cnt_nxt_s  = cnt_r;
    busy_nxt_s = {NUM_REGS{1'b0}};
    ovf_nxt_s  = ovf_r;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (inc_s[r] && dec_s[r]) begin
        cnt_nxt_s[r] = cnt_r[r];
      end else if (inc_s[r]) begin
        if (cnt_r[r] == 2'd3) begin
          ovf_nxt_s = 1'b1;
        end else begin
          cnt_nxt_s[r] = cnt_r[r] + 2'd1;
        end
      end else if (dec_s[r] && (cnt_r[r] != 2'd0)) begin
        cnt_nxt_s[r] = cnt_r[r] - 2'd1;
      end else begin
        cnt_nxt_s[r] = cnt_r[r];
      end
      busy_nxt_s[r] = (cnt_nxt_s[r] != 2'd0);
    end
  end

  // State, scoreboard and write-port registers.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pri_r      <= PRI0;
      cnt_r      <= {NUM_REGS{2'd0}};
      busy_r     <= {NUM_REGS{1'b0}};
      ovf_r      <= 1'b0;
      rf_we_r    <= 1'b0;
      rf_wreg_r  <= {REG_AW{1'b0}};
      rf_wdata_r <= {WORD_SIZE{1'b0}};
    end else begin
      pri_r   <= pri_nxt_s;
      cnt_r   <= cnt_nxt_s;
      busy_r  <= busy_nxt_s;
      ovf_r   <= ovf_nxt_s;
      rf_we_r <= xfer_s;
      if (xfer_s) begin
        rf_wreg_r  <= win_reg_s;
        rf_wdata_r <= win_data_s;
      end
    end
  end

  assign rf_we       = rf_we_r;
  assign rf_wreg     = rf_wreg_r;
  assign rf_wdata    = rf_wdata_r;
  assign busy        = busy_r;
  assign sb_overflow = ovf_r;

endmodule
